// File: rtl/wb_initiator.sv
// Wishbone classic (B4) initiator: accepts one read/write command per handshake,
// runs single or incrementing-burst accesses, and returns one response per beat.
module wb_initiator #(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [31:0]       cmd_adr,
    input  logic [31:0]       cmd_dat,
    input  logic [3:0]        cmd_sel,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              rsp_last,
    output logic              busy,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic               last_q, last_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            tmr_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            tmr_q   <= tmr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        len_d   = len_q;
        beat_d  = beat_q;
        tmr_d   = tmr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    len_d   = cmd_len;
                    beat_d  = '0;
                    tmr_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                tmr_d = tmr_q + 1'b1;
                if (wbm_err_i) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    last_d  = 1'b1;
                    state_d = RESP;
                end else if (wbm_ack_i) begin
                    rdata_d = we_q ? '0 : wbm_dat_i;
                    last_d  = (beat_q == len_q);
                    state_d = RESP;
                end else if ((TIMEOUT_CYC != 0) && (tmr_q == TMR_LAST)) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    last_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    last_d  = 1'b0;
                    // last_q already folds in err/timeout, so it alone decides abort vs next beat
                    if (!last_q) begin
                        beat_d  = beat_q + 1'b1;
                        adr_d   = adr_q + 32'd4;
                        tmr_d   = '0;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign wbm_cyc_o   = (state_q != IDLE);
    assign wbm_stb_o   = (state_q == REQ);
    assign rsp_valid   = (state_q == RESP);
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;
    assign rsp_last    = last_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: configurable Wishbone slave, directed vector table,
// reset-in-burst sequence and randomized commands checked against a beat-level model.
module tb_wb_initiator;

    localparam int LEN_W = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic [3:0]  cmd_len = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, rsp_last, busy;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack, err;

    always #5 clk = ~clk;

    wb_initiator #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_last(rsp_last), .busy(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
        .wbm_ack_i(ack), .wbm_err_i(err)
    );

    // Slave: ack after lat+1 stb cycles (registered) or same cycle (comb); err at err_adr
    int          lat = 0;
    bit          comb = 1'b0, noack = 1'b0, err_en = 1'b0, force_ack = 1'b0;
    logic [31:0] err_adr = '0;
    logic        ack_q, err_q;
    int          cnt;
    logic        hit;

    assign hit   = err_en && (adr == err_adr);
    assign dat_i = adr ^ 32'h0000FFFF;
    assign ack   = (comb ? (stb && !noack && !hit) : ack_q) | force_ack;
    assign err   = comb ? (stb && !noack && hit) : err_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0; err_q <= 1'b0; cnt <= 0;
        end else begin
            ack_q <= 1'b0; err_q <= 1'b0;
            if (stb && !ack_q && !err_q && !comb) begin
                if (cnt >= lat) begin
                    cnt <= 0;
                    if (!noack) begin
                        if (hit) err_q <= 1'b1;
                        else     ack_q <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end else if (!stb) begin
                cnt <= 0;
            end
        end
    end

    typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; } acc_t;
    typedef struct { logic [31:0] rdata; logic err; logic tmo; logic last; } rsp_t;
    typedef struct {
        logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic [3:0] len;
        int lat; bit comb; bit noack; bit err_en; int err_beat; int bp; int nrsp; int nstb;
    } vec_t;

    acc_t bus_log[$];
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   stb_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stb) stb_cnt++;
            if (stb && cyc && (ack || err)) bus_log.push_back('{adr, we, dat_o, sel});
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); @(negedge clk); #1;
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [3:0] l, input int lt,
                                input bit cb, input bit na, input bit ee, input int eb,
                                input int bp, input int nr, input int ns);
        vec_t v;
        v.we = w; v.adr = a; v.dat = d; v.sel = s; v.len = l; v.lat = lt; v.comb = cb;
        v.noack = na; v.err_en = ee; v.err_beat = eb; v.bp = bp; v.nrsp = nr; v.nstb = ns;
        return v;
    endfunction

    // Beat-level reference: addresses step by 4 with wrap; err/timeout ends the command
    function automatic void build_model(input vec_t v);
        exp_rsp.delete();
        exp_acc.delete();
        for (int i = 0; i <= int'(v.len); i++) begin
            logic [31:0] a;
            a = v.adr + 32'(4 * i);
            if (v.noack) begin
                exp_rsp.push_back('{32'h0, 1'b0, 1'b1, 1'b1});
                break;
            end
            exp_acc.push_back('{a, v.we, v.dat, v.sel});
            if (v.err_en && i == v.err_beat) begin
                exp_rsp.push_back('{32'h0, 1'b1, 1'b0, 1'b1});
                break;
            end
            exp_rsp.push_back('{v.we ? 32'h0 : (a ^ 32'h0000FFFF), 1'b0, 1'b0, i == int'(v.len)});
        end
    endfunction

    task automatic run_cmd(input vec_t v);
        int  nrsp = 0, cyc_n = 0, held = 0, base;
        bit  pulsed = 1'b0, want_stb = 1'b0;
        build_model(v);
        lat = v.lat; comb = v.comb; noack = v.noack; err_en = v.err_en;
        err_adr = v.adr + 32'(4 * v.err_beat);
        bus_log.delete();
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat;
        cmd_sel = v.sel; cmd_len = v.len;
        base = stb_cnt;
        step();
        cmd_valid = 1'b0;
        chk("accept_cyc_stb_busy_ready", 32'({cyc, stb, busy, cmd_ready}), 32'h0000000E);
        while (nrsp < exp_rsp.size() && cyc_n < 3000) begin
            force_ack = 1'b0;
            if (want_stb) begin
                chk("next_beat_stb", 32'({stb, rsp_valid}), 32'h2);
                want_stb = 1'b0;
            end
            rsp_ready = (v.bp == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid) begin
                rsp_t e;
                e = exp_rsp[nrsp];
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_cyc_stb_err_tmo_last", 32'({cyc, stb, rsp_err, rsp_timeout, rsp_last}),
                    32'({1'b1, 1'b0, e.err, e.tmo, e.last}));
                if (v.bp == 2 && nrsp == 0 && held < 5) begin
                    rsp_ready = 1'b0;
                    held++;
                end
                if (v.noack && !pulsed) begin
                    force_ack = 1'b1;
                    rsp_ready = 1'b0;
                    pulsed = 1'b1;
                end
                if (rsp_ready) begin
                    nrsp++;
                    if (!e.last) want_stb = 1'b1;
                end
            end
            step();
            cyc_n++;
        end
        force_ack = 1'b0;
        rsp_ready = 1'b0;
        if (cyc_n >= 3000) begin
            checks++; errors++;
            $display("FAIL rsp_wait: got %0d responses expected %0d", nrsp, exp_rsp.size());
        end
        chk("end_cyc_stb_busy_ready_valid", 32'({cyc, stb, busy, cmd_ready, rsp_valid}), 32'h2);
        if (v.nrsp >= 0) chk("rsp_count", 32'(nrsp), 32'(v.nrsp));
        if (v.nstb >= 0) chk("stb_cycles", 32'(stb_cnt - base), 32'(v.nstb));
        chk("acc_count", 32'(bus_log.size()), 32'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < bus_log.size(); i++) begin
            chk("acc_adr", bus_log[i].adr, exp_acc[i].adr);
            chk("acc_we_sel", 32'({bus_log[i].we, bus_log[i].sel}), 32'({exp_acc[i].we, exp_acc[i].sel}));
            if (exp_acc[i].we) chk("acc_dat", bus_log[i].dat, exp_acc[i].dat);
        end
    endtask

    vec_t vecs[8];

    initial begin
        //              we adr           dat           sel  len lat cb na ee eb bp nrsp nstb
        vecs[0] = mk(1, 32'h30000000, 32'h00001234, 4'hF, 0,  0,  1, 0, 0, 0, 0, 1,  1);
        vecs[1] = mk(0, 32'h30000010, 32'h0,        4'hF, 3,  0,  0, 0, 0, 0, 0, 4,  8);
        vecs[2] = mk(0, 32'h30000100, 32'h0,        4'hF, 1,  0,  0, 0, 0, 0, 2, 2,  4);
        vecs[3] = mk(0, 32'h30000200, 32'h0,        4'hF, 3,  0,  0, 0, 1, 1, 0, 2,  4);
        vecs[4] = mk(0, 32'h30000300, 32'h0,        4'hF, 2,  0,  0, 1, 0, 0, 0, 1,  16);
        vecs[5] = mk(1, 32'h30000400, 32'hA5A55A5A, 4'h3, 15, 0,  1, 0, 0, 0, 0, 16, 16);
        vecs[6] = mk(0, 32'hFFFFFFF8, 32'h0,        4'hC, 3,  0,  1, 0, 0, 0, 1, 4,  4);
        vecs[7] = mk(1, 32'h30000500, 32'h0BADF00D, 4'h1, 2,  2,  0, 0, 1, 2, 1, 3,  12);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_cyc_stb_we_busy_valid", 32'({cyc, stb, we, busy, rsp_valid}), 32'h0);
        rst_n = 1'b1;
        step();
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_adr", adr, 32'h0);
        chk("reset_dat_sel", dat_o ^ 32'(sel), 32'h0);
        chk("reset_rsp", rsp_rdata | 32'({rsp_err, rsp_timeout, rsp_last}), 32'h0);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Reset while a burst is waiting on a silent slave
        noack = 1'b1; comb = 1'b0; err_en = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h30000600; cmd_dat = 32'h55;
        cmd_sel = 4'hF; cmd_len = 4'd3;
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("pre_reset_stb", 32'({cyc, stb}), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({cyc, stb, busy, rsp_valid, we}), 32'h0);
        chk("async_reset_adr", adr, 32'h0);
        step();
        noack = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_reset_ready_busy_valid", 32'({cmd_ready, busy, rsp_valid, cyc}), 32'h8);

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            logic [3:0] l;
            l = 4'($urandom_range(0, 15));
            v = mk(1'($urandom_range(0, 1)), {$urandom(), 2'b00} >> 0 & 32'hFFFFFFFC, $urandom(),
                   4'($urandom_range(0, 15)), l, $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0, 1'b0, 1'b0, $urandom_range(0, int'(l)), 1, -1, -1);
            v.noack  = ($urandom_range(0, 9) == 0);
            v.err_en = !v.noack && ($urandom_range(0, 4) == 0);
            run_cmd(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
